// File: rtl/alu_defs.sv
// Shared definitions for the bit-serial SUB/SBB/CMP engine: FSM encoding,
// 8085 PSW flag positions, and the compact flag set carried between stages.
package alu_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // 8085 PSW bit positions
  localparam int PSW_S  = 7;
  localparam int PSW_Z  = 6;
  localparam int PSW_AC = 4;
  localparam int PSW_P  = 2;
  localparam int PSW_CY = 0;

  typedef struct packed {
    logic s;
    logic z;
    logic ac;
    logic p;
    logic cy;
  } flags_t;

  // Pack the flag set into PSW layout for consumers that want the byte form.
  function automatic logic [7:0] psw_byte(input flags_t f);
    logic [7:0] b;
    b         = 8'h02;
    b[PSW_S]  = f.s;
    b[PSW_Z]  = f.z;
    b[PSW_AC] = f.ac;
    b[PSW_P]  = f.p;
    b[PSW_CY] = f.cy;
    return b;
  endfunction

endpackage

// File: rtl/add1b.sv
// 1-bit full-adder cell, used as the serial bit slice of the subtract engine.
module add1b (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/alu_sub8s.sv
// Bit-serial 8085 subtractor: R = A - B - iC, one bit per clock, LSB first,
// computed as A + ~B + ~iC through a single add1b slice.
// Optional macro ALU_SUB_AUXC_EN: keeps the bit-3 carry capture for oAC;
// when undefined oAC is tied low and the capture register is absent.
module alu_sub8s
  import alu_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oR,
  output logic             oS,
  output logic             oZ,
  output logic             oAC,
  output logic             oP,
  output logic             oCY
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, r_q;
  logic             cy_q, busy_q, done_q;
  flags_t           flags_q, flags_d;
  logic             sum, cout, ac_bit;

`ifdef ALU_SUB_AUXC_EN
  logic ac_q;
  assign ac_bit = ac_q;
`else
  assign ac_bit = 1'b0;
`endif

  // Serial slice: b_q already holds ~B, cy_q was preset to ~iC.
  add1b u_bit (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (cy_q),
    .s_o (sum),
    .c_o (cout)
  );

  // Flags of the completed difference, latched on the DONE edge.
  always_comb begin
    flags_d    = '0;
    flags_d.s  = acc_q[WIDTH-1];
    flags_d.z  = (acc_q == '0);
    flags_d.ac = ac_bit;
    flags_d.p  = ~^acc_q;
    flags_d.cy = ~cy_q;
  end

  // Control FSM and datapath; outputs all registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      flags_q <= '0;
`ifdef ALU_SUB_AUXC_EN
      ac_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            a_q     <= iA;
            b_q     <= ~iB;
            cy_q    <= ~iC;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          acc_q <= {sum, acc_q[WIDTH-1:1]};
          cy_q  <= cout;
          cnt_q <= cnt_q + 1'b1;
`ifdef ALU_SUB_AUXC_EN
          if (cnt_q == CW'(3)) ac_q <= cout;
`endif
          if (cnt_q == CW'(WIDTH-1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          r_q     <= acc_q;
          flags_q <= flags_d;
          // Back-to-back accept with no IDLE gap.
          if (iStart) begin
            a_q     <= iA;
            b_q     <= ~iB;
            cy_q    <= ~iC;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oR    = r_q;
  assign oS    = flags_q.s;
  assign oZ    = flags_q.z;
  assign oAC   = flags_q.ac;
  assign oP    = flags_q.p;
  assign oCY   = flags_q.cy;

endmodule

// File: tb/tb_alu_sub8s.sv
// Scoreboard bench for alu_sub8s: stimulus pushes hand-computed results with
// their due cycle; a monitor pops and compares on every oDone.
module tb_alu_sub8s;

  localparam int W = 8;
`ifdef ALU_SUB_AUXC_EN
  localparam logic ACEN = 1'b1;
`else
  localparam logic ACEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         iStart = 1'b0;
  logic [W-1:0] iA = '0, iB = '0;
  logic         iC = 1'b0;
  logic         oBusy, oDone, oS, oZ, oAC, oP, oCY;
  logic [W-1:0] oR;

  alu_sub8s #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .iStart(iStart), .iA(iA), .iB(iB), .iC(iC),
    .oBusy(oBusy), .oDone(oDone), .oR(oR), .oS(oS), .oZ(oZ),
    .oAC(oAC), .oP(oP), .oCY(oCY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] r;
    logic [4:0] f;   // {S,Z,AC,P,CY}
    int         due;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] a, b;
    logic       c;
    logic [7:0] r;
    logic [4:0] f;
  } vec_t;
  vec_t v[5];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every oDone must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && oDone) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: oDone with empty scoreboard, oR=%0h cycle %0d", oR, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", {24'h0, oR}, {24'h0, e.r});
        chk("flags", {27'h0, oS, oZ, oAC, oP, oCY}, {27'h0, e.f});
        chk("latency", cyc, e.due);
      end
    end
  end

  function automatic logic [4:0] acmask(input logic [4:0] f);
    return f & {2'b11, ACEN, 2'b11};
  endfunction

  // Issue one request; leave iStart low and scramble operands afterwards.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] r, input logic [4:0] f);
    @(negedge clk);
    iA = a; iB = b; iC = c; iStart = 1'b1;
    @(posedge clk); #1;
    sbq.push_back('{r: r, f: acmask(f), due: cyc + 9});
    iStart = 1'b0;
    iA = 8'($urandom); iB = 8'($urandom); iC = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results never appeared", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, nb;
    //                a      b     c     r      S Z AC P CY
    v[0] = '{8'h3A, 8'h1C, 1'b0, 8'h1E, 5'b00010};
    v[1] = '{8'h05, 8'h05, 1'b0, 8'h00, 5'b01110};
    v[2] = '{8'h00, 8'h01, 1'b0, 8'hFF, 5'b10011};
    v[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 5'b01010};
    v[4] = '{8'h10, 8'h0F, 1'b0, 8'h01, 5'b00000};

    // Reset state
    #1;
    chk("reset_outputs", {19'h0, oBusy, oDone, oR, oS, oZ, oAC, oP, oCY}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors, each with busy-length and result-hold checks
    for (int i = 0; i < 5; i++) begin
      launch(v[i].a, v[i].b, v[i].c, v[i].r, v[i].f);
      nb = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (oBusy) nb++;
        if (k == 3 && i > 0) chk("hold_during_shift", {24'h0, oR}, {24'h0, v[i-1].r});
      end
      chk("busy_cycles", nb, 8);
      drain();
    end

    // iStart pulsed during SHIFT is ignored
    launch(8'h3A, 8'h1C, 1'b0, 8'h1E, 5'b00010);
    repeat (3) @(negedge clk);
    iA = 8'h55; iB = 8'h11; iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    repeat (14) @(negedge clk);
    drain();

    // iStart held through DONE: back-to-back, second result 9 cycles later
    @(negedge clk);
    iA = 8'h10; iB = 8'h0F; iC = 1'b1; iStart = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    sbq.push_back('{r: 8'h00, f: acmask(5'b01010), due: t0 + 9});
    iA = 8'h10; iB = 8'h0F; iC = 1'b0;
    while (cyc < t0 + 9) begin
      @(posedge clk); #1;
    end
    sbq.push_back('{r: 8'h01, f: acmask(5'b00000), due: cyc + 9});
    iStart = 1'b0;
    drain();

    // Reset in the middle of SHIFT: no oDone, outputs cleared
    @(negedge clk);
    iA = 8'h3A; iB = 8'h1C; iC = 1'b0; iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midop_reset_outputs", {19'h0, oBusy, oDone, oR, oS, oZ, oAC, oP, oCY}, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset_held_outputs", {19'h0, oBusy, oDone, oR, oS, oZ, oAC, oP, oCY}, 32'h0);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", {31'h0, oBusy}, 32'h0);

    // Recovery operation after reset
    launch(8'h05, 8'h03, 1'b0, 8'h02, 5'b00100);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
